// File: rtl/key_debounce_if.sv
`timescale 1ns/1ps
// Key pins in, debounced level and event pulses out.
interface key_debounce_if #(
  parameter int unsigned KEY_NUM = 2
);

  logic [KEY_NUM-1:0] key;          // raw pins, 0 = pressed
  logic [KEY_NUM-1:0] key_state;    // debounced level, 1 = pressed
  logic [KEY_NUM-1:0] key_press;    // one-cycle accepted press
  logic [KEY_NUM-1:0] key_release;  // one-cycle accepted release
  logic [KEY_NUM-1:0] key_long;     // one-cycle long-press event

  // Board side: drives the pins, consumes the events
  modport master (
    output key,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long
  );

  // Debouncer side
  modport slave (
    input  key,
    output key_state,
    output key_press,
    output key_release,
    output key_long
  );

endinterface

// File: rtl/key_debounce.sv
`timescale 1ns/1ps
// Multi-channel key reader: per-key 2-flop synchroniser and debounce FSM
// producing a stable level plus press / release / long-press pulses.
module key_debounce #(
  parameter int unsigned KEY_NUM       = 2,
  parameter int unsigned CLK_FREQ      = 27_000_000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000
) (
  input  logic         clk,
  input  logic         rst,
  key_debounce_if.slave kif
);

  localparam int unsigned DB_CNT   = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int unsigned LONG_CNT = (CLK_FREQ / 1000) * LONG_PRESS_MS;
  localparam int unsigned DB_W     = $clog2(DB_CNT);
  localparam int unsigned LONG_W   = $clog2(LONG_CNT);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_FILT = 3'd1,
    PRESSED    = 3'd2,
    HELD       = 3'd3,
    REL_FILT   = 3'd4
  } state_e;

  for (genvar g = 0; g < int'(KEY_NUM); g++) begin : g_ch

    logic              sync1_q;
    logic              sync2_q;
    state_e            fsm_q;
    state_e            fsm_d;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   db_cnt_d;
    logic [LONG_W-1:0] long_cnt_q;
    logic [LONG_W-1:0] long_cnt_d;
    logic              long_done_q;
    logic              long_done_d;
    logic              key_state_q;
    logic              key_state_d;
    logic              key_press_q;
    logic              key_press_d;
    logic              key_release_q;
    logic              key_release_d;
    logic              key_long_q;
    logic              key_long_d;
    logic              key_low;
    logic              db_done;
    logic              long_hit;

    // Two-flop synchroniser; idles released (high) out of reset
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= kif.key[g];
        sync2_q <= sync1_q;
      end
    end

    assign key_low  = ~sync2_q;
    assign db_done  = (db_cnt_q == DB_W'(DB_CNT - 1));
    assign long_hit = (long_cnt_q == LONG_W'(LONG_CNT - 1));

    // FSM state, counters and long-press flag
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fsm_q       <= IDLE;
        db_cnt_q    <= '0;
        long_cnt_q  <= '0;
        long_done_q <= 1'b0;
      end else begin
        fsm_q       <= fsm_d;
        db_cnt_q    <= db_cnt_d;
        long_cnt_q  <= long_cnt_d;
        long_done_q <= long_done_d;
      end
    end

    // Next-state decision from the synchronised level and counter terminals
    always_comb begin
      fsm_d = fsm_q;
      unique case (fsm_q)
        IDLE: begin
          if (key_low) fsm_d = PRESS_FILT;
        end
        PRESS_FILT: begin
          if (!key_low)     fsm_d = IDLE;
          else if (db_done) fsm_d = PRESSED;
        end
        PRESSED: begin
          if (!key_low)      fsm_d = REL_FILT;
          else if (long_hit) fsm_d = HELD;
        end
        HELD: begin
          if (!key_low) fsm_d = REL_FILT;
        end
        REL_FILT: begin
          // A low during release filtering is bounce: resume where we were
          if (key_low)      fsm_d = long_done_q ? HELD : PRESSED;
          else if (db_done) fsm_d = IDLE;
        end
        default: fsm_d = IDLE;
      endcase
    end

    // Counter updates and event pulses; long_cnt is frozen outside PRESSED
    always_comb begin
      db_cnt_d      = db_cnt_q;
      long_cnt_d    = long_cnt_q;
      long_done_d   = long_done_q;
      key_press_d   = 1'b0;
      key_release_d = 1'b0;
      key_long_d    = 1'b0;
      unique case (fsm_q)
        IDLE: begin
          db_cnt_d = '0;
        end
        PRESS_FILT: begin
          if (!key_low) begin
            db_cnt_d = '0;
          end else if (db_done) begin
            db_cnt_d    = '0;
            long_cnt_d  = '0;
            key_press_d = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end
        PRESSED: begin
          if (!key_low) begin
            db_cnt_d = '0;
          end else if (long_hit) begin
            long_done_d = 1'b1;
            key_long_d  = 1'b1;
          end else begin
            long_cnt_d = long_cnt_q + LONG_W'(1);
          end
        end
        HELD: begin
          long_done_d = 1'b1;
          if (!key_low) db_cnt_d = '0;
        end
        REL_FILT: begin
          if (key_low) begin
            db_cnt_d = '0;
          end else if (db_done) begin
            db_cnt_d      = '0;
            long_done_d   = 1'b0;
            key_release_d = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end
        default: begin
          db_cnt_d    = '0;
          long_cnt_d  = '0;
          long_done_d = 1'b0;
        end
      endcase
      key_state_d = (fsm_d inside {PRESSED, HELD, REL_FILT});
    end

    // Registered outputs so nothing combinational reaches the pins
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        key_state_q   <= 1'b0;
        key_press_q   <= 1'b0;
        key_release_q <= 1'b0;
        key_long_q    <= 1'b0;
      end else begin
        key_state_q   <= key_state_d;
        key_press_q   <= key_press_d;
        key_release_q <= key_release_d;
        key_long_q    <= key_long_d;
      end
    end

    assign kif.key_state[g]   = key_state_q;
    assign kif.key_press[g]   = key_press_q;
    assign kif.key_release[g] = key_release_q;
    assign kif.key_long[g]    = key_long_q;

  end : g_ch

endmodule
